// File: rtl/nf_router_pkg.sv
// Shared types and default address map for the nf_router slave-select controller.
// Holds the FSM state encoding and the masked-compare helper used by the decoder.
package nf_router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_MISS = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
    localparam logic [31:0] GPIO_BASE = 32'h0001_0000;
    localparam logic [31:0] PWM_BASE  = 32'h0002_0000;
    localparam logic [31:0] MAP_MASK  = 32'hFFFF_0000;
    localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

    function automatic logic addr_match(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] mask
    );
        return (addr & mask) == (base & mask);
    endfunction

endpackage

// File: rtl/nf_router_dec.sv
// Combinational address decoder: masked compare per slave, lowest index wins.
// Produces a one-hot (or zero) hit vector plus a miss flag.
module nf_router_dec_param
    import nf_router_pkg::*;
#(
    parameter int                     Slave_n   = 4,
    parameter logic [Slave_n*32-1:0]  Addr_base = {Slave_n{32'h0000_0000}},
    parameter logic [Slave_n*32-1:0]  Addr_mask = {Slave_n{32'hFFFF_0000}}
) (
    input  logic [31:0]        addr,
    output logic [Slave_n-1:0] hit,
    output logic               miss
);

    logic found_s;

    // Priority select: the first matching slave claims the access.
    always_comb begin
        hit     = '0;
        found_s = 1'b0;
        for (int i = 0; i < Slave_n; i++) begin
            if (!found_s && addr_match(addr, Addr_base[32*i +: 32], Addr_mask[32*i +: 32])) begin
                hit[i]  = 1'b1;
                found_s = 1'b1;
            end else begin
                hit[i]  = 1'b0;
            end
        end
        miss = ~found_s;
    end

endmodule

// File: rtl/nf_router_ctrl.sv
// Single-master to N-slave request router with address decode, ack wait and timeout.
// All master/slave-facing outputs come straight from flops.
module nf_router_ctrl
    import nf_router_pkg::*;
#(
    parameter int                     Slave_n   = 4,
    parameter logic [Slave_n*32-1:0]  Addr_base = {Slave_n{32'h0000_0000}},
    parameter logic [Slave_n*32-1:0]  Addr_mask = {Slave_n{32'hFFFF_0000}},
    parameter int                     Timeout   = 255
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [31:0]             addr_m,
    input  logic                    we_m,
    input  logic [31:0]             wd_m,
    input  logic                    req_m,
    output logic [31:0]             rd_m,
    output logic                    req_ack_m,
    output logic                    err_m,
    output logic [31:0]             addr_s,
    output logic [31:0]             wd_s,
    output logic [Slave_n-1:0]      we_s,
    output logic [Slave_n-1:0]      req_s,
    input  logic [Slave_n*32-1:0]   rd_s,
    input  logic [Slave_n-1:0]      req_ack_s
);

    localparam int              CntW    = $clog2(Timeout + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(Timeout - 1);

    state_t              state_r, state_nxt_s;
    logic [Slave_n-1:0]  sel_r, sel_nxt_s, hit_s;
    logic [CntW-1:0]     cnt_r, cnt_nxt_s;
    logic                err_r, err_nxt_s, we_r, we_nxt_s, miss_s, ack_sel_s;
    logic [31:0]         rd_nxt_s, addr_nxt_s, wd_nxt_s, rd_sel_s;
    logic [Slave_n-1:0]  req_s_nxt_s, we_s_nxt_s;
    logic                ack_m_nxt_s, err_m_nxt_s;

    nf_router_dec_param #(
        .Slave_n   (Slave_n),
        .Addr_base (Addr_base),
        .Addr_mask (Addr_mask)
    ) u_dec (
        .addr (addr_m),
        .hit  (hit_s),
        .miss (miss_s)
    );

    // Read data and ack are taken only from the selected slave; others are masked off.
    always_comb begin
        rd_sel_s = 32'h0000_0000;
        for (int i = 0; i < Slave_n; i++) begin
            rd_sel_s = rd_sel_s | (rd_s[32*i +: 32] & {32{sel_r[i]}});
        end
    end

    assign ack_sel_s = |(req_ack_s & sel_r);

    // Next-state and next-register logic; output flops are derived from the next state.
    always_comb begin
        state_nxt_s = state_r;
        sel_nxt_s   = sel_r;
        cnt_nxt_s   = cnt_r;
        err_nxt_s   = err_r;
        we_nxt_s    = we_r;
        rd_nxt_s    = rd_m;
        addr_nxt_s  = addr_s;
        wd_nxt_s    = wd_s;
        case (state_r)
            ST_IDLE: begin
                if (req_m && !miss_s) begin
                    addr_nxt_s  = addr_m;
                    wd_nxt_s    = wd_m;
                    we_nxt_s    = we_m;
                    sel_nxt_s   = hit_s;
                    cnt_nxt_s   = '0;
                    state_nxt_s = ST_WAIT;
                end else if (req_m) begin
                    state_nxt_s = ST_MISS;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // Counter tops out at Timeout on the exit cycle, which still fits CntW.
                cnt_nxt_s = cnt_r + CntW'(1);
                if (ack_sel_s) begin
                    rd_nxt_s    = rd_sel_s;
                    err_nxt_s   = 1'b0;
                    state_nxt_s = ST_RESP;
                end else if (cnt_r == CntLast) begin
                    rd_nxt_s    = ERR_RDATA;
                    err_nxt_s   = 1'b1;
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_MISS: begin
                rd_nxt_s    = ERR_RDATA;
                err_nxt_s   = 1'b1;
                state_nxt_s = ST_RESP;
            end
            ST_RESP: begin
                sel_nxt_s   = '0;
                cnt_nxt_s   = '0;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                sel_nxt_s   = '0;
                cnt_nxt_s   = '0;
                state_nxt_s = ST_IDLE;
            end
        endcase

        if (state_nxt_s == ST_WAIT) begin
            req_s_nxt_s = sel_nxt_s;
            we_s_nxt_s  = sel_nxt_s & {Slave_n{we_nxt_s}};
        end else begin
            req_s_nxt_s = '0;
            we_s_nxt_s  = '0;
        end

        if (state_nxt_s == ST_RESP) begin
            ack_m_nxt_s = 1'b1;
            err_m_nxt_s = err_nxt_s;
        end else begin
            ack_m_nxt_s = 1'b0;
            err_m_nxt_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath, counter and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sel_r     <= '0;
            cnt_r     <= '0;
            err_r     <= 1'b0;
            we_r      <= 1'b0;
            rd_m      <= 32'h0000_0000;
            addr_s    <= 32'h0000_0000;
            wd_s      <= 32'h0000_0000;
            req_s     <= '0;
            we_s      <= '0;
            req_ack_m <= 1'b0;
            err_m     <= 1'b0;
        end else begin
            sel_r     <= sel_nxt_s;
            cnt_r     <= cnt_nxt_s;
            err_r     <= err_nxt_s;
            we_r      <= we_nxt_s;
            rd_m      <= rd_nxt_s;
            addr_s    <= addr_nxt_s;
            wd_s      <= wd_nxt_s;
            req_s     <= req_s_nxt_s;
            we_s      <= we_s_nxt_s;
            req_ack_m <= ack_m_nxt_s;
            err_m     <= err_m_nxt_s;
        end
    end

endmodule

// File: tb/tb_nf_router_ctrl.sv
// Scoreboard bench for nf_router_ctrl: 4 slaves, default map plus slave3 at 0x0003_0000,
// Timeout=8; a second instance covers overlapping base addresses.
module tb_nf_router_ctrl;
    import nf_router_pkg::*;

    localparam logic [127:0] BASE_MAP = {32'h0003_0000, PWM_BASE, GPIO_BASE, RAM_BASE};
    localparam logic [127:0] BASE_OVL = {32'h0003_0000, PWM_BASE, RAM_BASE, RAM_BASE};
    localparam logic [127:0] MASK_MAP = {4{MAP_MASK}};

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [31:0]  addr_m = '0, wd_m = '0, rd_m, addr_s, wd_s;
    logic         we_m = 1'b0, req_m = 1'b0, req_ack_m, err_m;
    logic [3:0]   we_s, req_s, req_ack_s = '0;
    logic [127:0] rd_s = '0;

    logic [31:0]  addr_m2 = '0, rd_m2, addr_s2, wd_s2;
    logic         req_m2 = 1'b0, req_ack_m2, err_m2;
    logic [3:0]   we_s2, req_s2, req_ack_s2 = '0;
    logic [127:0] rd_s2 = '0;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    nf_router_ctrl #(.Slave_n(4), .Addr_base(BASE_MAP), .Addr_mask(MASK_MAP), .Timeout(8)) dut (
        .clk(clk), .resetn(resetn), .addr_m(addr_m), .we_m(we_m), .wd_m(wd_m), .req_m(req_m),
        .rd_m(rd_m), .req_ack_m(req_ack_m), .err_m(err_m), .addr_s(addr_s), .wd_s(wd_s),
        .we_s(we_s), .req_s(req_s), .rd_s(rd_s), .req_ack_s(req_ack_s)
    );

    nf_router_ctrl #(.Slave_n(4), .Addr_base(BASE_OVL), .Addr_mask(MASK_MAP), .Timeout(8)) dut_ovl (
        .clk(clk), .resetn(resetn), .addr_m(addr_m2), .we_m(1'b0), .wd_m(32'h0000_0000), .req_m(req_m2),
        .rd_m(rd_m2), .req_ack_m(req_ack_m2), .err_m(err_m2), .addr_s(addr_s2), .wd_s(wd_s2),
        .we_s(we_s2), .req_s(req_s2), .rd_s(rd_s2), .req_ack_s(req_ack_s2)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Response monitor: every completion must match the oldest expected entry.
    always @(negedge clk) begin
        if (resetn && req_ack_m) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_ack", 32'(req_ack_m), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_val("rd_m", rd_m, e.rd);
                check_val("err_m", 32'(err_m), 32'(e.err));
            end
        end
    end

    // One master transaction with a slave model answering after ack_wait WAIT cycles.
    task automatic run_txn(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input int slv, input int ack_wait, input int noise,
                           input logic [31:0] rdata, input logic [3:0] exp_req,
                           input logic [31:0] exp_rd, input logic exp_err,
                           input int exp_hi, input int exp_lat);
        int   lat, hi;
        logic done;
        sb_q.push_back('{rd: exp_rd, err: exp_err});
        @(posedge clk); #1;
        addr_m = a; we_m = w; wd_m = d; req_m = 1'b1;
        lat = 0; hi = 0; done = 1'b0;
        @(posedge clk);
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            req_ack_s = '0;
            if (req_ack_m) begin
                done  = 1'b1;
                req_m = 1'b0;
            end else if (req_s != 4'b0000) begin
                check_val("req_s", 32'(req_s), 32'(exp_req));
                check_val("we_s", 32'(we_s), w ? 32'(exp_req) : 32'd0);
                check_val("addr_s", addr_s, a);
                if (w) check_val("wd_s", wd_s, d);
                if (slv >= 0 && hi == ack_wait) begin
                    req_ack_s[slv] = 1'b1;
                    rd_s[32*slv +: 32] = rdata;
                end else if (noise >= 0 && hi == 0) begin
                    req_ack_s[noise] = 1'b1;
                    rd_s[32*noise +: 32] = 32'hBAD0_BAD0;
                end
                hi++;
            end
        end
        req_m = 1'b0;
        if (!done) check_val("ack_never_seen", 32'd0, 32'd1);
        check_val("latency", 32'(lat), 32'(exp_lat));
        check_val("req_cycles", 32'(hi), 32'(exp_hi));
    endtask

    // Overlapping map: slave0 must win; an ack from slave1 must be ignored.
    task automatic run_overlap();
        int   lat, hi;
        logic done;
        @(posedge clk); #1;
        addr_m2 = 32'h0000_0040; req_m2 = 1'b1;
        lat = 0; hi = 0; done = 1'b0;
        @(posedge clk);
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            req_ack_s2 = '0;
            if (req_ack_m2) begin
                done   = 1'b1;
                req_m2 = 1'b0;
                check_val("ovl_rd_m", rd_m2, 32'h0000_00AA);
                check_val("ovl_err_m", 32'(err_m2), 32'd0);
            end else if (req_s2 != 4'b0000) begin
                check_val("ovl_req_s", 32'(req_s2), 32'h1);
                if (hi == 0) begin
                    req_ack_s2[1] = 1'b1;
                    rd_s2[63:32]  = 32'h1111_1111;
                end else if (hi == 2) begin
                    req_ack_s2[0] = 1'b1;
                    rd_s2[31:0]   = 32'h0000_00AA;
                end
                hi++;
            end
        end
        req_m2 = 1'b0;
        if (!done) check_val("ovl_ack_never_seen", 32'd0, 32'd1);
        check_val("ovl_latency", 32'(lat), 32'd4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_req_s", 32'(req_s), 32'd0);
        check_val("rst_ack", 32'(req_ack_m), 32'd0);
        check_val("rst_rd_m", rd_m, 32'd0);
        check_val("rst_addr_s", addr_s, 32'd0);
        resetn = 1'b1;

        run_txn(32'h0001_0004, 1'b0, 32'h0, 1, 0, -1, 32'hA5A5_0001, 4'b0010, 32'hA5A5_0001, 1'b0, 1, 2);
        run_txn(32'h0002_0010, 1'b1, 32'h1234_5678, 2, 2, -1, 32'h0000_0000, 4'b0100, 32'h0000_0000, 1'b0, 3, 4);
        run_txn(32'h0001_0008, 1'b0, 32'h0, 1, 0, -1, 32'h0BAD_0001, 4'b0010, 32'h0BAD_0001, 1'b0, 1, 2);
        run_txn(32'h0005_0000, 1'b0, 32'h0, -1, 0, -1, 32'h0, 4'b0000, 32'h0000_0000, 1'b1, 0, 2);
        run_txn(32'h0003_0008, 1'b0, 32'h0, 3, 1, 0, 32'h3333_CAFE, 4'b1000, 32'h3333_CAFE, 1'b0, 2, 3);
        run_txn(32'h0000_0100, 1'b0, 32'h0, 0, 7, -1, 32'h7777_0007, 4'b0001, 32'h7777_0007, 1'b0, 8, 9);
        run_txn(32'h0000_0100, 1'b0, 32'h0, -1, 0, -1, 32'h0, 4'b0001, 32'h0000_0000, 1'b1, 8, 9);

        // Late ack from slave0 after the timeout response must be dropped.
        @(negedge clk);
        @(negedge clk);
        req_ack_s[0] = 1'b1;
        rd_s[31:0]   = 32'hDEAD_0000;
        @(negedge clk);
        req_ack_s = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("late_ack_req_ack_m", 32'(req_ack_m), 32'd0);
            check_val("late_ack_req_s", 32'(req_s), 32'd0);
        end
        check_val("late_ack_rd_hold", rd_m, 32'd0);

        run_overlap();

        // Reset in the middle of a write waiting on slave0.
        run_txn(32'h0001_0000, 1'b0, 32'h0, 1, 0, -1, 32'h0000_5A5A, 4'b0010, 32'h0000_5A5A, 1'b0, 1, 2);
        @(posedge clk); #1;
        addr_m = 32'h0000_0200; we_m = 1'b1; wd_m = 32'h5555_AAAA; req_m = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("pre_rst_req_s", 32'(req_s), 32'h1);
        resetn = 1'b0;
        req_m  = 1'b0;
        #1;
        check_val("mid_rst_req_s", 32'(req_s), 32'd0);
        check_val("mid_rst_we_s", 32'(we_s), 32'd0);
        check_val("mid_rst_addr_s", addr_s, 32'd0);
        check_val("mid_rst_wd_s", wd_s, 32'd0);
        check_val("mid_rst_rd_m", rd_m, 32'd0);
        check_val("mid_rst_ack", 32'(req_ack_m), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("in_rst_ack", 32'(req_ack_m), 32'd0);
        resetn = 1'b1;
        we_m = 1'b0;
        run_txn(32'h0000_0300, 1'b0, 32'h0, 0, 0, -1, 32'h0000_C0DE, 4'b0001, 32'h0000_C0DE, 1'b0, 1, 2);

        repeat (3) @(negedge clk);
        check_val("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
